// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and constants for the MMU translation stage
package mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam logic [1:0] CFG_VBASE  = 2'd0;
  localparam logic [1:0] CFG_VLIMIT = 2'd1;
  localparam logic [1:0] CFG_PBASE  = 2'd2;
  localparam logic [1:0] CFG_VALID  = 2'd3;

  localparam logic [2:0] MAX_AXI_SIZE = 3'd2;

  typedef struct packed {
    logic [31:0] vbase;
    logic [31:0] vlimit;
    logic [31:0] pbase;
    logic        valid;
  } seg_entry_t;

  // Last byte of the burst; bit 32 set means the burst wraps the address space.
  function automatic logic [32:0] burst_end(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [7:0]  len);
    logic [32:0] bytes;
    bytes = (33'(len) + 33'd1) << size;
    return {1'b0, addr} + bytes - 33'd1;
  endfunction

endpackage

// File: rtl/mmu_seg_table.sv
// rtl/mmu_seg_table.sv - segment table register file, one write port, one indexed read port
module mmu_seg_table
  import mmu_pkg::*;
#(
  parameter  int N_ENTRIES = 8,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_field,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output seg_entry_t       rd_entry
);

  logic [31:0]          vbase  [N_ENTRIES];
  logic [31:0]          vlimit [N_ENTRIES];
  logic [31:0]          pbase  [N_ENTRIES];
  logic [N_ENTRIES-1:0] valid;

  // Only the valid bits need a reset; address fields are meaningless until enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we && wr_field == CFG_VALID) begin
      valid[wr_idx] <= wr_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      case (wr_field)
        CFG_VBASE:  vbase[wr_idx]  <= wr_data;
        CFG_VLIMIT: vlimit[wr_idx] <= wr_data;
        CFG_PBASE:  pbase[wr_idx]  <= wr_data;
        default: ;
      endcase
    end
  end

  assign rd_entry.vbase  = vbase[rd_idx];
  assign rd_entry.vlimit = vlimit[rd_idx];
  assign rd_entry.pbase  = pbase[rd_idx];
  assign rd_entry.valid  = valid[rd_idx];

endmodule

// File: rtl/mmu_xlate_unit.sv
// rtl/mmu_xlate_unit.sv - virtual-to-physical translation for one AXI address channel
module mmu_xlate_unit
  import mmu_pkg::*;
#(
  parameter  int N_ENTRIES = 8,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic             m_axi_clk,
  input  logic             m_aresetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [2:0]       req_size,
  input  logic [7:0]       req_len,
  output logic [31:0]      p_addr,
  output logic             t_done,
  output logic             t_fault,
  output logic [31:0]      fault_addr,
  output logic [15:0]      fault_cnt,
  input  logic             cfg_we,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_field,
  input  logic [31:0]      cfg_wdata
);

  state_e           state, state_nx;
  logic [31:0]      cap_addr;
  logic [2:0]       cap_size;
  logic [7:0]       cap_len;
  logic [31:0]      end_addr;
  logic [IDX_W-1:0] idx;
  logic [32:0]      calc_end;
  logic             hit;
  seg_entry_t       ent;

  mmu_seg_table #(.N_ENTRIES(N_ENTRIES)) u_table (
    .clk      (m_axi_clk),
    .rst_n    (m_aresetn),
    .we       (cfg_we && state == ST_IDLE),
    .wr_idx   (cfg_idx),
    .wr_field (cfg_field),
    .wr_data  (cfg_wdata),
    .rd_idx   (idx),
    .rd_entry (ent)
  );

  assign req_ready = (state == ST_IDLE);
  assign cfg_ready = (state == ST_IDLE);
  assign calc_end  = burst_end(cap_addr, cap_size, cap_len);
  assign hit       = ent.valid && (cap_addr >= ent.vbase) && (end_addr <= ent.vlimit);

  always_ff @(posedge m_axi_clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nx = ST_CALC;
      ST_CALC:  state_nx = (cap_size > MAX_AXI_SIZE || calc_end[32]) ? ST_FAULT : ST_SCAN;
      ST_SCAN: begin
        if (hit)                                 state_nx = ST_DONE;
        else if (idx == IDX_W'(N_ENTRIES - 1))   state_nx = ST_FAULT;
      end
      ST_DONE:  state_nx = ST_IDLE;
      ST_FAULT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Pulses are registered from the next state so they coincide with DONE/FAULT.
  always_ff @(posedge m_axi_clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      cap_addr   <= '0;
      cap_size   <= '0;
      cap_len    <= '0;
      end_addr   <= '0;
      idx        <= '0;
      p_addr     <= '0;
      t_done     <= 1'b0;
      t_fault    <= 1'b0;
      fault_addr <= '0;
      fault_cnt  <= '0;
    end else begin
      t_done  <= (state_nx == ST_DONE);
      t_fault <= (state_nx == ST_FAULT);
      if (state == ST_IDLE && req_valid) begin
        cap_addr <= req_addr;
        cap_size <= req_size;
        cap_len  <= req_len;
      end
      if (state == ST_CALC) begin
        end_addr <= calc_end[31:0];
        idx      <= '0;
      end
      if (state == ST_SCAN) begin
        if (hit) p_addr <= ent.pbase + (cap_addr - ent.vbase);
        else     idx    <= idx + IDX_W'(1);
      end
      if (state_nx == ST_FAULT) begin
        fault_addr <= cap_addr;
        if (fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mmu_xlate_unit.sv
// tb/tb_mmu_xlate_unit.sv - scoreboard bench for mmu_xlate_unit
module tb_mmu_xlate_unit;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic [31:0] p_addr;
  logic        t_done;
  logic        t_fault;
  logic [31:0] fault_addr;
  logic [15:0] fault_cnt;
  logic        cfg_we;
  logic        cfg_ready;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_wdata;

  mmu_xlate_unit #(.N_ENTRIES(8)) dut (
    .m_axi_clk  (clk),
    .m_aresetn  (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_len    (req_len),
    .p_addr     (p_addr),
    .t_done     (t_done),
    .t_fault    (t_fault),
    .fault_addr (fault_addr),
    .fault_cnt  (fault_cnt),
    .cfg_we     (cfg_we),
    .cfg_ready  (cfg_ready),
    .cfg_idx    (cfg_idx),
    .cfg_field  (cfg_field),
    .cfg_wdata  (cfg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          flt;
    int          lat;
    logic [31:0] pa;
    logic [31:0] fa;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  int          n_resp = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] m_pa = '0;
  logic [31:0] m_fa = '0;
  logic [15:0] m_fc = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (t_done === 1'b1 || t_fault === 1'b1)) begin
      exp_t e;
      chk("done_fault_exclusive", {31'd0, t_done & t_fault}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse actual=done%0b_fault%0b required=none", t_done, t_fault);
      end else begin
        e = sb.pop_front();
        chk("resp_kind_fault", {31'd0, t_fault}, {31'd0, e.flt});
        chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
        chk("p_addr", p_addr, e.pa);
        if (e.flt) begin
          chk("fault_addr", fault_addr, e.fa);
          chk("fault_cnt", {16'd0, fault_cnt}, {16'd0, e.fc});
        end
      end
      n_resp++;
    end
  end

  task automatic cfg_wr(input logic [2:0] idx, input logic [1:0] fld, input logic [31:0] d);
    @(negedge clk);
    cfg_idx = idx; cfg_field = fld; cfg_wdata = d; cfg_we = 1'b1;
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic prog(input logic [2:0] idx, input logic [31:0] vb, input logic [31:0] vl,
                      input logic [31:0] pb, input bit v);
    cfg_wr(idx, CFG_VBASE, vb);
    cfg_wr(idx, CFG_VLIMIT, vl);
    cfg_wr(idx, CFG_PBASE, pb);
    cfg_wr(idx, CFG_VALID, {31'd0, v});
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] s, input logic [7:0] l,
                       input bit flt, input int lat, input logic [31:0] pa);
    exp_t e;
    @(negedge clk);
    req_addr = a; req_size = s; req_len = l; req_valid = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF; req_size = 3'd7; req_len = 8'hFF;
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (flt) begin
      m_fa = a;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end else begin
      m_pa = pa;
    end
    e.flt = flt; e.lat = lat; e.pa = m_pa; e.fa = m_fa; e.fc = m_fc;
    sb.push_back(e);
  endtask

  task automatic wait_resp();
    int  start;
    bit  got;
    start = n_resp;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (n_resp != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL resp_timeout actual=no_pulse required=pulse_within_40");
      sb.delete();
    end
  endtask

  task automatic xlate(input logic [31:0] a, input logic [2:0] s, input logic [7:0] l,
                       input bit flt, input int lat, input logic [31:0] pa);
    issue(a, s, l, flt, lat, pa);
    wait_resp();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_pulses", {30'd0, t_done, t_fault}, 32'd0);
    chk("rst_p_addr", p_addr, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_fault_cnt", {16'd0, fault_cnt}, 32'd0);

    // Entry 0 hit, exact fill, one-byte overrun
    prog(3'd0, 32'h1000_0000, 32'h1000_FFFF, 32'h8000_0000, 1'b1);
    xlate(32'h1000_0040, 3'd2, 8'd3, 1'b0, 3, 32'h8000_0040);
    xlate(32'h1000_FFF0, 3'd2, 8'd3, 1'b0, 3, 32'h8000_FFF0);
    xlate(32'h1000_FFF0, 3'd2, 8'd4, 1'b1, 10, 32'h0);

    // CALC-stage faults: wrap past 4 GiB, oversize beat
    xlate(32'hFFFF_FFFC, 3'd2, 8'd1, 1'b1, 2, 32'h0);
    xlate(32'h1000_0000, 3'd3, 8'd0, 1'b1, 2, 32'h0);

    // Scan position and priority
    cfg_wr(3'd0, CFG_VALID, 32'd0);
    prog(3'd5, 32'h1000_0000, 32'h1000_FFFF, 32'h9000_0000, 1'b1);
    xlate(32'h1000_0040, 3'd2, 8'd3, 1'b0, 8, 32'h9000_0040);
    prog(3'd2, 32'h1000_0000, 32'h1000_FFFF, 32'hA000_0000, 1'b1);
    xlate(32'h1000_0040, 3'd2, 8'd3, 1'b0, 5, 32'hA000_0040);

    // Inverted segment never hits
    prog(3'd1, 32'h2000_0000, 32'h1FFF_FFFF, 32'hC000_0000, 1'b1);
    xlate(32'h2000_0000, 3'd0, 8'd0, 1'b1, 10, 32'h0);

    // Table write during a translation is dropped
    issue(32'h1000_0040, 3'd2, 8'd3, 1'b0, 5, 32'hA000_0040);
    cfg_idx = 3'd2; cfg_field = CFG_PBASE; cfg_wdata = 32'hB000_0000; cfg_we = 1'b1;
    @(negedge clk);
    chk("cfg_ready_calc", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    chk("cfg_ready_scan", {31'd0, cfg_ready}, 32'd0);
    cfg_we = 1'b0;
    wait_resp();
    cfg_wr(3'd2, CFG_PBASE, 32'hB000_0000);
    xlate(32'h1000_0040, 3'd2, 8'd3, 1'b0, 5, 32'hB000_0040);

    // Reset during SCAN
    issue(32'h3000_0000, 3'd0, 8'd0, 1'b1, 10, 32'h0);
    sb.delete();
    m_pa = '0; m_fa = '0; m_fc = '0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("arst_pulses", {30'd0, t_done, t_fault}, 32'd0);
    chk("arst_p_addr", p_addr, 32'd0);
    chk("arst_fault_addr", fault_addr, 32'd0);
    chk("arst_fault_cnt", {16'd0, fault_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    xlate(32'h1000_0040, 3'd2, 8'd3, 1'b1, 10, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mmu_xlate_unit.md
Name: mmu_xlate_unit

Overview:
- Virtual-to-physical translation stage that serves one address channel of the AXI MMU wrapper (read or write); instantiated twice.
- Consumes the buffered request address, size and length from the wrapper's rx address buffer. Returns the physical address with a one-cycle done pulse, which drives the wrapper's tx address stage and the rx buffer pop.
- Translation uses a software-programmed segment table, scanned sequentially. A burst that does not fit one valid segment raises a fault instead of done.

Parameters:
N_ENTRIES, 8, number of segment table entries (2..32)
IDX_W, $clog2(N_ENTRIES), entry index width (derived, not overridden)

Ports:
m_axi_clk  in  1  clock, master-side domain
m_aresetn  in  1  reset; asynchronous assert, active-low
req_valid  in  1  request present on req_addr/size/len
req_ready  out  1  block can accept; high only in IDLE
req_addr  in  32  virtual start address (tmp_araddr/tmp_awaddr)
req_size  in  3  AXI size (tmp_arsize/tmp_awsize)
req_len  in  8  AXI len (tmp_arlen/tmp_awlen)
p_addr  out  32  translated physical address; held until next done
t_done  out  1  one-cycle pulse: translation succeeded
t_fault  out  1  one-cycle pulse: translation failed
fault_addr  out  32  virtual address of most recent fault
fault_cnt  out  16  saturating fault counter
cfg_we  in  1  table write strobe
cfg_ready  out  1  table write accepted (high only in IDLE)
cfg_idx  in  IDX_W  entry index
cfg_field  in  2  0=vbase, 1=vlimit (inclusive), 2=pbase, 3=valid (wdata[0])
cfg_wdata  in  32  write data

Behaviour:
- Reset (async, m_aresetn=0):
  - state IDLE; req_ready=1; cfg_ready=1.
  - t_done=0, t_fault=0, p_addr=0, fault_addr=0, fault_cnt=0.
  - All entry valid bits 0. vbase, vlimit and pbase are don't-care.
  - Reset mid-scan aborts the scan with no done or fault pulse.
- States: IDLE, CALC, SCAN, DONE, FAULT.
- IDLE:
  - req_valid & req_ready captures addr/size/len → CALC.
  - cfg_we & cfg_ready writes the field; visible from the next cycle.
  - cfg_we ignored in every other state. No cfg write is ever lost: software waits for cfg_ready.
- CALC (1 cycle):
  - bytes = (len+1) << size; end = addr + bytes - 1, computed in 33 bits.
  - size > 2 (bus is 32-bit) or end[32]=1 → FAULT.
  - Otherwise index=0 → SCAN.
- SCAN (one entry per cycle, lowest index wins):
  - Hit condition: valid[i] & addr >= vbase[i] & end[31:0] <= vlimit[i].
  - Hit → p_addr <= pbase[i] + (addr - vbase[i]) mod 2^32 → DONE.
  - Miss at index N_ENTRIES-1 → FAULT; otherwise index+1.
- DONE (1 cycle): t_done=1 → IDLE.
- FAULT (1 cycle):
  - t_fault=1; fault_addr <= addr; fault_cnt += 1, saturating at 16'hFFFF.
  - p_addr unchanged → IDLE.
- Latency (cycle 1 = first cycle after the accept edge):
  - Hit at entry k: t_done in cycle k+3.
  - Table miss: t_fault in cycle N_ENTRIES+2.
  - CALC fault: t_fault in cycle 2.
- t_done and t_fault are never high together. Both are registered outputs.
- One outstanding request. req_ready=0 from the accept edge until back in IDLE.
  - Upstream holds or advances req_* freely after acceptance; captured values are used.
  - A new request is accepted at the earliest in the cycle after DONE/FAULT.
- Table contents cannot change during a translation (cfg_ready=0), so a scan sees a consistent table.
- Boundaries:
  - vlimit < vbase → entry never hits.
  - Burst exactly filling a segment (end == vlimit) → hit.
  - Burst crossing vlimit by one byte → that entry misses.

Decomposition:
- Shared package mmu_pkg:
  - state enum (IDLE, CALC, SCAN, DONE, FAULT)
  - cfg_field encodings CFG_VBASE=0, CFG_VLIMIT=1, CFG_PBASE=2, CFG_VALID=3
  - MAX_AXI_SIZE=3'd2
  - segment entry struct (vbase, vlimit, pbase, valid)
- One sub-module, mmu_seg_table: register-file table with a write port and a single indexed read port feeding the SCAN comparator.
- FSM and arithmetic stay in mmu_xlate_unit.

Test Plan:
- Entry 0 {vbase=0x1000_0000, vlimit=0x1000_FFFF, pbase=0x8000_0000, valid}; req addr=0x1000_0040, size=2, len=3 → t_done in cycle 3, p_addr=0x8000_0040.
- Same range programmed in entry 5 only → t_done in cycle 8; entries 2 and 5 both matching → entry 2's pbase used.
- Entry 0 as above; addr=0x1000_FFF0, size=2, len=3 (end=0x1000_FFFF) → done. Same with len=4 → t_fault in cycle 10 (N=8), fault_addr=0x1000_FFF0, fault_cnt=1.
- addr=0xFFFF_FFFC, size=2, len=1 → t_fault in cycle 2. size=3 with any address → t_fault in cycle 2.
- cfg_we pulsed during SCAN → ignored (entry unchanged, cfg_ready=0). Same write in IDLE → applied; the next request uses the new pbase.
- Assert m_aresetn low during SCAN → outputs are at their reset values immediately, with no pulse. The first request after reset with an empty table → fault.
